// File: rtl/morphle_pkg.sv
// Shared morphle definitions: the 3-bit ycconfig cell codes and the loader FSM state type.
package morphle_pkg;

  localparam logic [2:0] CodeSpace = 3'b000;
  localparam logic [2:0] CodePlus  = 3'b001;
  localparam logic [2:0] CodeMinus = 3'b010;
  localparam logic [2:0] CodeVbar  = 3'b011;
  localparam logic [2:0] CodeOne   = 3'b100;
  localparam logic [2:0] CodeZero  = 3'b101;
  localparam logic [2:0] CodeY     = 3'b110;
  localparam logic [2:0] CodeN     = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSlo,
    StShi,
    StFin
  } ld_state_e;

endpackage

// File: rtl/ycconfig_bitser.sv
// 3-bit code serializer for the ycconfig chain, with tail readback deserializer.
// Phase outputs are registered from the FSM next state so confclk and cbitin never glitch.
module ycconfig_bitser
  import morphle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ld_state_e  state_q_i,
  input  ld_state_e  state_d_i,
  input  logic       load_i,
  input  logic [2:0] code_i,
  input  logic       cbitret_i,
  output logic       last_o,
  output logic       confclk_o,
  output logic       cbitin_o,
  output logic [2:0] rd_code_o,
  output logic       rd_valid_o
);

  logic [2:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] rd_sh_q, rd_sh_d;
  logic       confclk_q, cbitin_q, rd_valid_q;
  logic [2:0] rd_code_q;

  assign last_o = (state_q_i == StShi) && (idx_q == 2'd0);

  always_comb begin
    sh_d    = sh_q;
    idx_d   = idx_q;
    rd_sh_d = rd_sh_q;
    if (load_i) begin
      sh_d  = code_i;
      idx_d = 2'd2;
    end else if ((state_q_i == StShi) && (idx_q != 2'd0)) begin
      sh_d  = {sh_q[1:0], 1'b0};
      idx_d = idx_q - 2'd1;
    end
    // Tail bit is taken before the confclk rise that ends this SLO cycle.
    if (state_q_i == StSlo) begin
      rd_sh_d = {rd_sh_q[1:0], cbitret_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q       <= '0;
      idx_q      <= '0;
      rd_sh_q    <= '0;
      confclk_q  <= 1'b0;
      cbitin_q   <= 1'b0;
      rd_code_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      rd_sh_q    <= rd_sh_d;
      confclk_q  <= (state_d_i == StShi);
      if (state_d_i == StSlo) begin
        cbitin_q <= sh_d[2];
      end
      rd_valid_q <= last_o;
      if (last_o) begin
        rd_code_q <= rd_sh_q;
      end
    end
  end

  assign confclk_o  = confclk_q;
  assign cbitin_o   = cbitin_q;
  assign rd_code_o  = rd_code_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/ycconfig_loader.sv
// Frame loader for a chain of CELLS ycconfig cells: fetches one code per cell and shifts it
// in msb first with a registered confclk, reading back the previous chain contents.
module ycconfig_loader
  import morphle_pkg::*;
#(
  parameter int unsigned CELLS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       confclk,
  output logic       cbitin,
  input  logic       cbitret,
  output logic [2:0] rd_code,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = $clog2(CELLS + 1);
  localparam logic [CntW-1:0] CellsW = CntW'(CELLS);

  ld_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;
  logic            last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (code_valid) begin
          load    = 1'b1;
          state_d = StSlo;
        end
      end
      StSlo: state_d = StShi;
      StShi: begin
        if (last) begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_d < CellsW) ? StFetch : StFin;
        end else begin
          state_d = StSlo;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code_ready = (state_q == StFetch);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);

  ycconfig_bitser u_bitser (
    .clk        (clk),
    .reset      (reset),
    .state_q_i  (state_q),
    .state_d_i  (state_d),
    .load_i     (load),
    .code_i     (code),
    .cbitret_i  (cbitret),
    .last_o     (last),
    .confclk_o  (confclk),
    .cbitin_o   (cbitin),
    .rd_code_o  (rd_code),
    .rd_valid_o (rd_valid)
  );

endmodule

// File: tb/tb_ycconfig_loader.sv
// Bench for ycconfig_loader with a two-cell chain model; readback is checked by a
// scoreboard queue that a negedge monitor drains on every rd_valid strobe.
module tb_ycconfig_loader;
  import morphle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] code = 3'b000;
  logic       code_valid = 1'b0;
  logic       code_ready, confclk, cbitin, cbitret, rd_valid, busy, done;
  logic [2:0] rd_code;

  // Chain model: each cell shifts on confclk rise, cbitout is its msb.
  logic [2:0] head_sr = 3'b000;
  logic [2:0] tail_sr = 3'b000;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cc_edges = 0;
  int n_done = 0;
  int done_cyc = 0;
  int viol = 0;
  int start_cyc = 0;
  logic       last_cbitin = 1'b0;
  logic [2:0] exp_head;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  ycconfig_loader #(.CELLS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .confclk    (confclk),
    .cbitin     (cbitin),
    .cbitret    (cbitret),
    .rd_code    (rd_code),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done)
  );

  assign cbitret = tail_sr[2];

  always @(posedge confclk) begin
    head_sr <= {head_sr[1:0], cbitin};
    tail_sr <= {tail_sr[1:0], head_sr[2]};
    cc_edges = cc_edges + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: readback scoreboard, done pulses, cbitin stability while confclk is high.
  always @(negedge clk) begin
    if (confclk && (cbitin !== last_cbitin)) viol++;
    last_cbitin = cbitin;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %b, none expected (t=%0t)", rd_code, $time);
      end else begin
        exp_head = exp_q.pop_front();
        chk("rd_code", int'(rd_code), int'(exp_head));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_confclk"}, confclk, 0);
    chk({tag, "_cbitin"}, cbitin, 0);
    chk({tag, "_code_ready"}, code_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_code"}, int'(rd_code), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for FETCH, optionally stalls, hands over one code; exp_rd is the tail's old code.
  task automatic send_code(input logic [2:0] c, input logic [2:0] exp_rd, input int gap,
                           input bit poke);
    int t;
    logic held;
    t = 0;
    while (!code_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("code_ready_wait", code_ready, 1);
    if (!code_ready) return;
    held = cbitin;
    for (int i = 0; i < gap; i++) begin
      chk("stall_confclk", confclk, 0);
      chk("stall_cbitin", cbitin, held);
      @(negedge clk);
    end
    if (gap > 0) chk("stall_still_ready", code_ready, 1);
    exp_q.push_back(exp_rd);
    code = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    if (poke) begin
      @(negedge clk);
      chk("poke_in_shi", confclk, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    int e0;
    int d0;
    #6;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: PLUS, Y into an all-zero chain.
    e0 = cc_edges;
    d0 = n_done;
    start_frame();
    send_code(CodePlus, 3'b000, 0, 1'b0);
    send_code(CodeY, 3'b000, 0, 1'b0);
    wait_idle();
    chk("f1_done_count", n_done - d0, 1);
    chk("f1_done_cycle", done_cyc - start_cyc, 15);
    chk("f1_confclk_edges", cc_edges - e0, 6);
    chk("f1_head", int'(head_sr), 3'b110);
    chk("f1_tail", int'(tail_sr), 3'b001);

    // Frame 2: N, SPACE with a 5-cycle valid stall on the second code.
    e0 = cc_edges;
    d0 = n_done;
    start_frame();
    send_code(CodeN, 3'b001, 0, 1'b0);
    send_code(CodeSpace, 3'b110, 5, 1'b0);
    wait_idle();
    chk("f2_done_count", n_done - d0, 1);
    chk("f2_confclk_edges", cc_edges - e0, 6);
    chk("f2_head", int'(head_sr), 3'b000);
    chk("f2_tail", int'(tail_sr), 3'b111);

    // Frame 3: ONE, ZERO with a start pulse during SHI that must be ignored.
    d0 = n_done;
    start_frame();
    send_code(CodeOne, 3'b111, 0, 1'b1);
    send_code(CodeZero, 3'b000, 0, 1'b0);
    wait_idle();
    chk("f3_done_count", n_done - d0, 1);
    repeat (10) @(negedge clk);
    chk("f3_no_restart_busy", busy, 0);
    chk("f3_no_extra_done", n_done - d0, 1);
    chk("f3_head", int'(head_sr), 3'b101);
    chk("f3_tail", int'(tail_sr), 3'b100);

    // Frame 4: reset during the second SLO of MINUS; only its msb has been shifted in.
    start_frame();
    code = CodeMinus;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_slo", confclk, 0);
    e0 = cc_edges;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_confclk", cc_edges - e0, 0);
    chk("abort_head", int'(head_sr), 3'b010);
    chk("abort_tail", int'(tail_sr), 3'b001);

    // Frame 5: full recovery frame VBAR, Y.
    e0 = cc_edges;
    d0 = n_done;
    start_frame();
    send_code(CodeVbar, 3'b001, 0, 1'b0);
    send_code(CodeY, 3'b010, 0, 1'b0);
    wait_idle();
    chk("f5_done_count", n_done - d0, 1);
    chk("f5_confclk_edges", cc_edges - e0, 6);
    chk("f5_head", int'(head_sr), 3'b110);
    chk("f5_tail", int'(tail_sr), 3'b011);

    @(negedge clk);
    chk("rd_pending", exp_q.size(), 0);
    chk("cbitin_change_under_confclk", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
